// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: frame-controller state encoding and default timing.
// The transmit controller uses this package, and a later receive controller is meant to reuse it.
package uart_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

  localparam int UART_DBIT_DEFAULT    = 8;
  localparam int UART_OVS_DEFAULT     = 16;
  localparam int UART_SB_TICK_DEFAULT = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. It sends the start bit, then DBIT data bits LSB first, then the stop bit.
// The baud generator sits outside this block; its max_tick output drives s_tick.
module uart_tx_ctrl
  import uart_defs_pkg::*;
#(
  parameter int DBIT    = UART_DBIT_DEFAULT,
  parameter int SB_TICK = UART_SB_TICK_DEFAULT,
  parameter int OVS     = UART_OVS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SW = $clog2(max2(OVS, SB_TICK));
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE       = SW'(1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE       = NW'(1);

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_d;
  logic            done_d;

  // NOTE: every register, including the shift register, has an async reset.
  // A frame cut short by reset then leaves no stale data or count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments so every register updates from the values the previous cycle left.
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      tx           <= tx_d;
      tx_done_tick <= done_d;
    end
  end

  always_comb begin
    // NOTE: give every output a default before the case statement; a path that leaves one unassigned would infer a latch.
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          s_d     = '0;
          b_d     = din;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + N_ONE;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = ST_IDLE;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is a register, so its next value is taken from the next state to keep it aligned with that state.
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = b_d[0];
  end

  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (legal 5..8).
REQ-002 Parameter SB_TICK, default 16, stop-bit length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter OVS, default 16, oversampling ratio: s_tick pulses per start bit and per data bit.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 s_tick  input  1  one-clk-wide enable pulse from the BaudGenerator max_tick output (OVS x baud rate).
REQ-007 tx_start  input  1  request to send din; sampled only in IDLE.
REQ-008 din  input  DBIT  byte to transmit, LSB first; captured in the cycle tx_start is accepted.
REQ-009 tx  output  1  serial line, registered, idle high.
REQ-010 tx_busy  output  1  high in every state other than IDLE.
REQ-011 tx_done_tick  output  1  one-clk pulse marking the end of the stop bit.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-013 Tick counter s SHALL be sized ceil(log2(max(OVS,SB_TICK))) bits; bit counter n SHALL be sized ceil(log2(DBIT)) bits; shift register b SHALL be DBIT bits.
REQ-014 IDLE: tx=1; when tx_start=1, in the next cycle state=START, s=0, b=din and tx=0, whatever the value of s_tick.
REQ-015 START: tx=0; each s_tick increments s; when s_tick=1 and s=OVS-1, state becomes DATA with s=0 and n=0.
REQ-016 DATA: tx=b[0]; each s_tick increments s; when s_tick=1 and s=OVS-1, then s=0 and b shifts right by one.
REQ-017 DATA exit: at that shift, if n=DBIT-1 the state becomes STOP; otherwise n increments.
REQ-018 STOP: tx=1; each s_tick increments s; when s_tick=1 and s=SB_TICK-1, state becomes IDLE and tx_done_tick=1 for exactly that one clk.
REQ-019 When s_tick=0, s, n, b and the state SHALL hold, except for the IDLE accept in REQ-014.
REQ-020 tx_start asserted outside IDLE SHALL be ignored; there is no queueing and din is not re-captured.
REQ-021 tx_start held high through the tx_done_tick cycle SHALL start a new frame in the next cycle (back-to-back frames, no idle gap beyond one clk).
REQ-022 Counters SHALL never wrap: s resets to 0 at each bit boundary and n never exceeds DBIT-1.
REQ-023 Frame length SHALL be exactly OVS*(1+DBIT)+SB_TICK s_tick pulses from tx falling to tx_done_tick.

Reset
REQ-024 On rst_n low, immediately and independently of clk: state=IDLE, s=0, n=0, b=0, tx=1, tx_busy=0, tx_done_tick=0.
REQ-025 A reset asserted mid-frame SHALL abort the frame with no tx_done_tick; tx returns high immediately.
REQ-026 Release of rst_n SHALL be synchronised externally; the block takes no action on release other than resuming in IDLE.

Structure
REQ-027 State encodings (2-bit) and the default OVS/SB_TICK values SHALL live in a shared uart_defs include, reused by the future receive controller.
REQ-028 The tick/bit counting SHALL stay inline; the only natural sub-module is BaudGenerator, instantiated by the parent beside this block (not inside it), with max_tick connected to s_tick.

Verification
REQ-029 s_tick=1 every clk, din=0x55, one tx_start pulse -> tx pattern 0,1,0,1,0,1,0,1,0,1, each bit 16 clk; tx_done_tick exactly 160 clk after tx falls.
REQ-030 s_tick from BaudGenerator M=10, din=0xA3 -> each bit 160 clk; LSB-first bits 1,1,0,0,0,1,0,1; tx_busy high for the whole frame.
REQ-031 tx_start pulsed during DATA with din=0xFF -> frame content unchanged; no second frame starts.
REQ-032 tx_start held high, din=0x01 then 0x80 -> two frames, second start bit one clk after the first tx_done_tick.
REQ-033 rst_n asserted in the 4th data bit -> same cycle tx=1 and tx_busy=0; no tx_done_tick; a fresh frame after release is correct.
REQ-034 SB_TICK=32, DBIT=7 -> stop bit 32 s_ticks, frame length 16*8+32=160 s_ticks.
